// File: rtl/game_pkg.sv
// game_pkg: shared keypad types, key map and column reset pattern.
package game_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, RELEASE} kp_state_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    function automatic logic [1:0] low_row(input logic [3:0] rows);
        return !rows[0] ? 2'd0 : !rows[1] ? 2'd1 : !rows[2] ? 2'd2 : 2'd3;
    endfunction

    function automatic logic multi_low(input logic [3:0] rows);
        return ($countones(~rows) > 1);
    endfunction

endpackage

// File: rtl/row_sync.sv
// row_sync: 2-flop synchronizer for the active-low row lines, idle-high on restart.
module row_sync (
    input  logic       clk_fast,
    input  logic       restart,
    input  logic [3:0] d,
    output logic [3:0] q
);
    logic [3:0] meta;

    always_ff @(posedge clk_fast or posedge restart) begin
        if (restart) begin
            meta <= 4'hF;
            q    <= 4'hF;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_answer.sv
// keypad_answer: scans and debounces a 4x4 pinpad, one key_valid pulse per press with answer check.
// Define GHOST_REJECT_EN to treat multiple low rows as no key.
module keypad_answer
    import game_pkg::*;
#(
    parameter int SCAN_CYCLES     = 100000,
    parameter int DEBOUNCE_CYCLES = 2000000
) (
    input  logic       clk_fast,
    input  logic       restart,
    input  logic [3:0] rows_n,
    input  logic [3:0] expected,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       answer,
    output logic       key_down
);
    localparam int MAXC = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    kp_state_t     state;
    logic [3:0]    rows_s;
    logic [1:0]    col, cand_row, cand_col;
    logic [CW-1:0] scan_cnt, deb_cnt;
    logic [3:0]    code_q, press_code;
    logic          ans_q, multi, key_hit, cand_low;

    row_sync u_sync (
        .clk_fast (clk_fast),
        .restart  (restart),
        .d        (rows_n),
        .q        (rows_s)
    );

`ifdef GHOST_REJECT_EN
    assign multi = multi_low(rows_s);
`else
    assign multi = 1'b0;
`endif

    assign key_hit    = (rows_s != 4'hF) && !multi;
    assign cand_low   = !rows_s[cand_row] && !multi;
    assign press_code = KEY_MAP[cand_row][cand_col];

    always_ff @(posedge clk_fast or posedge restart) begin
        if (restart) begin
            state    <= SCAN;
            col      <= 2'd0;
            cand_row <= 2'd0;
            cand_col <= 2'd0;
            scan_cnt <= '0;
            deb_cnt  <= '0;
            code_q   <= 4'h0;
            ans_q    <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (key_hit) begin
                            state    <= DEBOUNCE;
                            cand_row <= low_row(rows_s);
                            cand_col <= col;
                            deb_cnt  <= '0;
                        end else begin
                            col <= col + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (!cand_low) begin
                        state    <= SCAN;
                        col      <= col + 2'd1;
                        scan_cnt <= '0;
                        deb_cnt  <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= PRESS;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESS: begin
                    state   <= RELEASE;
                    deb_cnt <= '0;
                    code_q  <= press_code;
                    ans_q   <= (press_code == expected);
                end
                RELEASE: begin
                    if (rows_s != 4'hF) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= SCAN;
                        col      <= col + 2'd1;
                        scan_cnt <= '0;
                        deb_cnt  <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    // key_code/answer bypass the holding registers during PRESS so they are valid with the pulse
    assign col_n     = ~((~COL_RESET) << col);
    assign key_valid = (state == PRESS);
    assign key_code  = key_valid ? press_code : code_q;
    assign answer    = key_valid ? (press_code == expected) : ans_q;
    assign key_down  = (state != SCAN);

endmodule

// File: tb/tb_keypad_answer.sv
// tb_keypad_answer: randomized keypad presses against a key-level model, scoreboard-checked pulses.
module tb_keypad_answer;

    localparam logic [3:0] KM [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    typedef struct {
        logic [3:0] code;
        logic       ans;
    } exp_t;

    logic       clk_fast = 1'b0;
    logic       restart  = 1'b1;
    logic [3:0] rows_n;
    logic [3:0] expected = 4'h0;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic       answer;
    logic       key_down;

    logic [3:0] pr [4];
    exp_t       sbq [$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] last_code = 4'h0;
    logic       last_ans  = 1'b0;

    keypad_answer #(.SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8)) dut (
        .clk_fast  (clk_fast),
        .restart   (restart),
        .rows_n    (rows_n),
        .expected  (expected),
        .col_n     (col_n),
        .key_valid (key_valid),
        .key_code  (key_code),
        .answer    (answer),
        .key_down  (key_down)
    );

    always #5 clk_fast = ~clk_fast;

    // physical pinpad: a pressed key pulls its row low only while its column is driven
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pr[r][c] && !col_n[c]) rows_n[r] = 1'b0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_fast);
            #2;
        end
    endtask

    task automatic set_key(input logic [3:0] k, input logic v);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (KM[r][c] == k) pr[r][c] = v;
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pr[r] = 4'h0;
    endtask

    task automatic expect_press(input logic [3:0] k);
        exp_t e;
        e.code = k;
        e.ans  = (k == expected);
        sbq.push_back(e);
        last_code = k;
        last_ans  = e.ans;
    endtask

    // align to the first cycle a given column is driven
    task automatic wait_col_start(input int c);
        int n = 0;
        logic [3:0] tgt;
        tgt = ~(4'b0001 << c);
        while (col_n == tgt && n < 40) begin tick(1); n++; end
        while (col_n != tgt && n < 40) begin tick(1); n++; end
        if (n >= 40) begin
            checks++;
            errors++;
            $display("FAIL wait_col timeout col=%0d col_n=%b", c, col_n);
        end
    endtask

    always @(negedge clk_fast) begin
        if (key_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got code %0h answer %0b expected no pulse", key_code, answer);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("pulse_key_code", key_code, e.code);
                chk("pulse_answer", answer, e.ans);
            end
        end
    end

    initial begin
        release_all();
        tick(3);
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_key_code", key_code, 0);
        chk("rst_answer", answer, 0);
        chk("rst_key_down", key_down, 0);
        restart = 1'b0;
        tick(1);
        chk("scan_col0", col_n, 4'b1110);
        tick(3);
        chk("scan_col1", col_n, 4'b1101);
        tick(4);
        chk("scan_col2", col_n, 4'b1011);
        tick(4);
        chk("scan_col3", col_n, 4'b0111);
        tick(4);
        chk("scan_wrap", col_n, 4'b1110);

        expected = 4'h5;
        wait_col_start(1);
        set_key(4'h5, 1'b1);
        expect_press(4'h5);
        tick(5);
        chk("debounce_key_down", key_down, 1);
        tick(25);
        release_all();
        tick(9);
        chk("release_key_down_hold", key_down, 1);
        tick(1);
        chk("release_key_down_drop", key_down, 0);
        chk("hold_code_5", key_code, 4'h5);
        chk("hold_answer_5", answer, 1);

        set_key(4'h5, 1'b1);
        expect_press(4'h5);
        tick(200);
        release_all();
        tick(10);
        expected = 4'h3;
        set_key(4'hA, 1'b1);
        expect_press(4'hA);
        tick(40);
        release_all();
        tick(20);
        chk("hold_code_A", key_code, 4'hA);
        chk("hold_answer_A", answer, 0);

        wait_col_start(1);
        set_key(4'h5, 1'b1);
        tick(5);
        release_all();
        tick(1);
        chk("bounce_key_down", key_down, 1);
        tick(2);
        chk("bounce_next_col", col_n, 4'b1011);
        chk("bounce_idle", key_down, 0);
        tick(20);

        expected = 4'h1;
        set_key(4'h1, 1'b1);
        set_key(4'h7, 1'b1);
`ifndef GHOST_REJECT_EN
        expect_press(4'h1);
`endif
        tick(40);
        release_all();
        tick(20);
        chk("ghost_code", key_code, last_code);

        for (int i = 0; i < 12; i++) begin
            logic [3:0] k;
            int hold;
            k = 4'($urandom_range(0, 15));
            expected = ($urandom_range(0, 1) == 1) ? k : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                set_key(k, 1'b1);
                tick($urandom_range(1, 5));
            end else begin
                hold = $urandom_range(40, 80);
                set_key(k, 1'b1);
                expect_press(k);
                tick(30);
                expected = 4'($urandom_range(0, 15));
                tick(hold - 30);
            end
            release_all();
            tick($urandom_range(20, 40));
            chk("rand_hold_code", key_code, last_code);
            chk("rand_hold_answer", answer, last_ans);
        end

        expected = 4'h9;
        set_key(4'h9, 1'b1);
        expect_press(4'h9);
        tick(40);
        chk("pre_restart_down", key_down, 1);
        restart = 1'b1;
        #1;
        chk("restart_key_code", key_code, 0);
        chk("restart_answer", answer, 0);
        chk("restart_col_n", col_n, 4'b1110);
        chk("restart_key_valid", key_valid, 0);
        chk("restart_key_down", key_down, 0);
        last_code = 4'h0;
        last_ans  = 1'b0;
        release_all();
        tick(2);
        restart = 1'b0;
        tick(40);
        chk("post_restart_code", key_code, 0);
        chk("post_restart_answer", answer, 0);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
